// File: rtl/neuron_activation.sv
// Neuron accumulate + ReLU + requantize stage: sums GROUPS sign-magnitude MAC partials plus bias per neuron.
// Optional argmax tracker over each layer is enabled by defining NEURON_ARGMAX_EN.
module neuron_activation #(
    parameter int SUM_W   = 21,
    parameter int GROUPS  = 8,
    parameter int OUT_W   = 8,
    parameter int SHIFT   = 7,
    parameter int NEURONS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             mac_valid,
    input  logic [SUM_W-1:0] mac_sum,
    input  logic [SUM_W-1:0] bias,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic [3:0]       out_idx,
    output logic             busy
`ifdef NEURON_ARGMAX_EN
    ,
    output logic             max_valid,
    output logic [3:0]       max_idx
`endif
);

    localparam int MAG_W   = SUM_W - 1;
    localparam int GW      = $clog2(GROUPS + 1);
    localparam int OUT_MAX = 2 ** (OUT_W - 1) - 1;
    localparam logic [GW-1:0] LAST_GRP = GW'(GROUPS - 1);
    localparam logic [3:0]    LAST_IDX = 4'(NEURONS - 1);

    logic [SUM_W-1:0] acc;
    logic [GW-1:0]    grp_cnt;
    logic [3:0]       neu_idx;
    logic [SUM_W-1:0] add_res;
    logic             is_last;

    // Sign-magnitude add with magnitude saturation; a zero result is always +0.
    function automatic logic [SUM_W-1:0] sm_add(input logic [SUM_W-1:0] a, input logic [SUM_W-1:0] b);
        logic [MAG_W-1:0] ma;
        logic [MAG_W-1:0] mb;
        logic [MAG_W-1:0] mag;
        logic [MAG_W:0]   sum;
        logic             sgn;
        ma  = a[MAG_W-1:0];
        mb  = b[MAG_W-1:0];
        sum = '0;
        if (a[MAG_W] == b[MAG_W]) begin
            sum = {1'b0, ma} + {1'b0, mb};
            mag = sum[MAG_W] ? {MAG_W{1'b1}} : sum[MAG_W-1:0];
            sgn = a[MAG_W];
        end else if (ma >= mb) begin
            mag = ma - mb;
            sgn = a[MAG_W];
        end else begin
            mag = mb - ma;
            sgn = b[MAG_W];
        end
        if (mag == '0) begin
            sgn = 1'b0;
        end
        return {sgn, mag};
    endfunction

    function automatic logic [OUT_W-1:0] activate(input logic [SUM_W-1:0] v);
        logic [MAG_W-1:0] m;
        m = v[MAG_W-1:0] >> SHIFT;
        if (v[MAG_W] || (v[MAG_W-1:0] == '0)) begin
            return '0;
        end else if (m > MAG_W'(OUT_MAX)) begin
            return {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            return {1'b0, m[OUT_W-2:0]};
        end
    endfunction

    assign add_res = (grp_cnt == '0) ? sm_add(bias, mac_sum) : sm_add(acc, mac_sum);
    assign is_last = (grp_cnt == LAST_GRP);
    assign busy    = (grp_cnt != '0);

    // clr only drops the partial neuron and index; an already registered pulse is left alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            grp_cnt   <= '0;
            neu_idx   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
        end else begin
            out_valid <= 1'b0;
            if (clr) begin
                grp_cnt <= '0;
                neu_idx <= '0;
            end else if (mac_valid) begin
                acc <= add_res;
                if (is_last) begin
                    grp_cnt   <= '0;
                    out_valid <= 1'b1;
                    out_data  <= activate(add_res);
                    out_idx   <= neu_idx;
                    neu_idx   <= (neu_idx == LAST_IDX) ? 4'd0 : neu_idx + 4'd1;
                end else begin
                    grp_cnt <= grp_cnt + GW'(1);
                end
            end
        end
    end

`ifdef NEURON_ARGMAX_EN
    logic [OUT_W-1:0] run_max;
    logic [3:0]       run_idx;
    logic             take_new;

    // Strict greater-than keeps the lower index on ties.
    assign take_new = (out_data > run_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_max   <= '0;
            run_idx   <= '0;
            max_valid <= 1'b0;
            max_idx   <= '0;
        end else begin
            max_valid <= 1'b0;
            if (clr) begin
                run_max <= '0;
                run_idx <= '0;
            end else if (out_valid) begin
                if (out_idx == LAST_IDX) begin
                    max_valid <= 1'b1;
                    max_idx   <= take_new ? out_idx : run_idx;
                    run_max   <= '0;
                    run_idx   <= '0;
                end else if (take_new) begin
                    run_max <= out_data;
                    run_idx <= out_idx;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_neuron_activation.sv
// Self-checking bench for neuron_activation: table-driven neurons plus reset, back-to-back, clr and argmax sequences.
module tb_neuron_activation;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        mac_valid;
    logic [20:0] mac_sum;
    logic [20:0] bias;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [3:0]  out_idx;
    logic        busy;
`ifdef NEURON_ARGMAX_EN
    logic        max_valid;
    logic [3:0]  max_idx;
    int          max_pulses = 0;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [20:0] bias;
        logic [20:0] first;
        logic [20:0] rest;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[9];

    neuron_activation dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .mac_valid (mac_valid),
        .mac_sum   (mac_sum),
        .bias      (bias),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .busy      (busy)
`ifdef NEURON_ARGMAX_EN
        ,
        .max_valid (max_valid),
        .max_idx   (max_idx)
`endif
    );

    always #5 clk = ~clk;

`ifdef NEURON_ARGMAX_EN
    always @(negedge clk) begin
        if (max_valid) max_pulses++;
    end
`endif

    function automatic logic [20:0] sm(input bit neg, input int mag);
        logic [31:0] m;
        m = mag;
        return {neg, m[19:0]};
    endfunction

    task automatic applyStimulus(input logic v, input logic [20:0] s, input logic [20:0] b, input logic c);
        @(negedge clk);
        mac_valid = v;
        mac_sum   = s;
        bias      = b;
        clr       = c;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Eight groups, then two idle cycles: pulse check, then pulse-end/hold check.
    task automatic runNeuron(input string name, input logic [20:0] b, input logic [20:0] first,
                             input logic [20:0] rest, input logic [7:0] exp_data, input logic [3:0] exp_idx);
        applyStimulus(1'b1, first, b, 1'b0);
        for (int g = 1; g < 8; g++) begin
            applyStimulus(1'b1, rest, sm(1'b1, 77777), 1'b0);
        end
        checkOutput({name, "_early_valid"}, 32'(out_valid), 32'd0);
        applyStimulus(1'b0, '0, '0, 1'b0);
        checkOutput({name, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({name, "_data"}, 32'(out_data), 32'(exp_data));
        checkOutput({name, "_idx"}, 32'(out_idx), 32'(exp_idx));
        checkOutput({name, "_busy"}, 32'(busy), 32'd0);
        applyStimulus(1'b0, '0, '0, 1'b0);
        checkOutput({name, "_pulse_end"}, 32'(out_valid), 32'd0);
        checkOutput({name, "_hold"}, 32'(out_data), 32'(exp_data));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{sm(0, 100),   sm(0, 1000),      sm(0, 1000),      8'h3F};
        vecs[1] = '{sm(0, 0),     sm(1, 200),       sm(1, 200),       8'h00};
        vecs[2] = '{sm(0, 300),   sm(1, 300),       sm(0, 0),         8'h00};
        vecs[3] = '{sm(0, 0),     sm(0, 1048575),   sm(0, 1048575),   8'h7F};
        vecs[4] = '{sm(1, 500),   sm(0, 2000),      sm(0, 2000),      8'h79};
        vecs[5] = '{sm(0, 64),    sm(0, 16),        sm(0, 16),        8'h01};
        vecs[6] = '{sm(1, 1000),  sm(0, 1000),      sm(0, 128),       8'h07};
        vecs[7] = '{sm(0, 16255), sm(0, 0),         sm(0, 0),         8'h7E};
        vecs[8] = '{sm(0, 16384), sm(0, 0),         sm(0, 0),         8'h7F};

        rst_n     = 1'b0;
        clr       = 1'b0;
        mac_valid = 1'b0;
        mac_sum   = '0;
        bias      = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_data", 32'(out_data), 32'd0);
        checkOutput("reset_idx", 32'(out_idx), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            runNeuron($sformatf("vec%0d", i), vecs[i].bias, vecs[i].first, vecs[i].rest,
                      vecs[i].exp_data, 4'(i));
        end

        // Asynchronous reset in the middle of a neuron.
        for (int g = 0; g < 3; g++) applyStimulus(1'b1, sm(0, 5000), sm(0, 5000), 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0);
        checkOutput("midacc_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_data", 32'(out_data), 32'd0);
        checkOutput("async_rst_idx", 32'(out_idx), 32'd0);
        checkOutput("async_rst_busy", 32'(busy), 32'd0);
        checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back: 16 groups -> two pulses 8 cycles apart.
        for (int c = 0; c <= 16; c++) begin
            applyStimulus(1'(c < 16), sm(0, 1000), sm(0, 0), 1'b0);
            checkOutput($sformatf("b2b_valid_c%0d", c), 32'(out_valid), 32'((c == 8) || (c == 16)));
            if (c == 8 || c == 16) begin
                checkOutput($sformatf("b2b_idx_c%0d", c), 32'(out_idx), (c == 8) ? 32'd0 : 32'd1);
                checkOutput($sformatf("b2b_data_c%0d", c), 32'(out_data), 32'h3E);
            end
        end

        // Same run with clr at cycle 4: partial neuron dropped, index restarts at 0.
        for (int c = 0; c <= 16; c++) begin
            applyStimulus(1'(c < 16), sm(0, 1000), sm(0, 0), 1'(c == 4));
            checkOutput($sformatf("clr_valid_c%0d", c), 32'(out_valid), 32'(c == 13));
            if (c == 13) begin
                checkOutput("clr_idx", 32'(out_idx), 32'd0);
                checkOutput("clr_data", 32'(out_data), 32'h3E);
            end
        end
        checkOutput("clr_tail_busy", 32'(busy), 32'd1);
        applyStimulus(1'b0, '0, '0, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b0);
        checkOutput("clr_clean_busy", 32'(busy), 32'd0);

`ifdef NEURON_ARGMAX_EN
        begin
            int layer_vals[10];
            layer_vals = '{5, 9, 9, 3, 0, 0, 0, 0, 0, 1};
            max_pulses = 0;
            for (int n = 0; n < 10; n++) begin
                runNeuron($sformatf("am%0d", n), sm(0, 0), sm(0, layer_vals[n] * 128), sm(0, 0),
                          8'(layer_vals[n]), 4'(n));
                if (n < 9) checkOutput($sformatf("am%0d_no_max", n), 32'(max_valid), 32'd0);
            end
            checkOutput("am_max_valid", 32'(max_valid), 32'd1);
            checkOutput("am_max_idx", 32'(max_idx), 32'd1);
            applyStimulus(1'b0, '0, '0, 1'b0);
            checkOutput("am_max_pulse_end", 32'(max_valid), 32'd0);
            checkOutput("am_max_idx_hold", 32'(max_idx), 32'd1);
            runNeuron("am10", sm(0, 0), sm(0, 256), sm(0, 0), 8'd2, 4'd0);
            checkOutput("am_pulse_count", 32'(max_pulses), 32'd1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
